// File: rtl/maxpool2_pkg.sv
// Shared layer-2 package cnn_pkg: image dimensions, derived pool-2 output size and a signed max.
package cnn_pkg;

    localparam int unsigned L2_IMAGE_WIDTH  = 13;
    localparam int unsigned L2_IMAGE_HEIGHT = 17;
    localparam int unsigned L2_CHANNELS     = 64;
    localparam int unsigned L2_DATA_BITS    = 32;

    localparam int unsigned POOL2_OUT_W = L2_IMAGE_WIDTH / 2;
    localparam int unsigned POOL2_OUT_H = L2_IMAGE_HEIGHT / 2;
    localparam int unsigned POOL2_ADDR_BITS = (POOL2_OUT_W > 1) ? $clog2(POOL2_OUT_W) : 1;

    typedef logic [L2_DATA_BITS-1:0] l2_data_t;

    function automatic l2_data_t smax(input l2_data_t a, input l2_data_t b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2_if.sv
// Pixel stream bundle into and out of maxpool2; frame_done exists only with MAXPOOL2_FRAME_DONE_EN.
interface maxpool2_if;
    import cnn_pkg::*;

    logic     valid_in;
    l2_data_t data_in  [L2_CHANNELS];
    logic     valid_out;
    l2_data_t data_out [L2_CHANNELS];

`ifdef MAXPOOL2_FRAME_DONE_EN
    logic frame_done;

    modport master (output valid_in, data_in, input valid_out, data_out, frame_done);
    modport slave  (input valid_in, data_in, output valid_out, data_out, frame_done);
`else
    modport master (output valid_in, data_in, input valid_out, data_out);
    modport slave  (input valid_in, data_in, output valid_out, data_out);
`endif

endinterface

// File: rtl/maxpool2_linebuf.sv
// One-row buffer of horizontal partial maxima, one entry per output column, all channels wide.
module maxpool2_linebuf
    import cnn_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [POOL2_ADDR_BITS-1:0] wr_addr,
    input  l2_data_t                   wr_data [L2_CHANNELS],
    input  logic [POOL2_ADDR_BITS-1:0] rd_addr,
    output l2_data_t                   rd_data [L2_CHANNELS]
);

    l2_data_t lb_q [POOL2_OUT_W][L2_CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < POOL2_OUT_W; e++) begin
                for (int ch = 0; ch < L2_CHANNELS; ch++) begin
                    lb_q[e][ch] <= '0;
                end
            end
        end else if (wr_en) begin
            lb_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = lb_q[rd_addr];

endmodule

// File: rtl/maxpool2.sv
// Streaming 2x2 stride-2 signed max-pool over raster pixels, all channels in parallel.
// Optional frame_done pulse on the last window is enabled by MAXPOOL2_FRAME_DONE_EN.
module maxpool2
    import cnn_pkg::*;
(
    input logic       clk,
    input logic       rst,
    maxpool2_if.slave pix
);

    localparam int unsigned ColBits = $clog2(L2_IMAGE_WIDTH + 1);
    localparam int unsigned RowBits = $clog2(L2_IMAGE_HEIGHT + 1);

    localparam logic [ColBits-1:0] ColLast    = ColBits'(L2_IMAGE_WIDTH - 1);
    localparam logic [RowBits-1:0] RowLast    = RowBits'(L2_IMAGE_HEIGHT - 1);
    localparam logic [ColBits-1:0] ColPoolEnd = ColBits'(2 * POOL2_OUT_W);
    localparam logic [RowBits-1:0] RowPoolEnd = RowBits'(2 * POOL2_OUT_H);
    localparam logic [ColBits-1:0] ColWinLast = ColBits'(2 * POOL2_OUT_W - 1);
    localparam logic [RowBits-1:0] RowWinLast = RowBits'(2 * POOL2_OUT_H - 1);

    logic [ColBits-1:0] col_q, col_d;
    logic [RowBits-1:0] row_q, row_d;

    l2_data_t hold_q     [L2_CHANNELS];
    l2_data_t hold_d     [L2_CHANNELS];
    l2_data_t rm         [L2_CHANNELS];
    l2_data_t lb_rd      [L2_CHANNELS];
    l2_data_t data_out_q [L2_CHANNELS];
    l2_data_t data_out_d [L2_CHANNELS];

    logic valid_out_q, valid_out_d;
    logic in_pool, hold_en, lb_wr, win_done;
    logic [POOL2_ADDR_BITS-1:0] lb_addr;

    // Trailing odd column/row still advance the counters but never touch hold/lb/outputs.
    always_comb begin
        in_pool  = (col_q < ColPoolEnd) && (row_q < RowPoolEnd);
        hold_en  = pix.valid_in && in_pool && !col_q[0];
        lb_wr    = pix.valid_in && in_pool && col_q[0] && !row_q[0];
        win_done = pix.valid_in && in_pool && col_q[0] && row_q[0];
        lb_addr  = POOL2_ADDR_BITS'(col_q >> 1);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix.valid_in) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid_out_d = win_done;
        for (int ch = 0; ch < L2_CHANNELS; ch++) begin
            rm[ch]         = smax(hold_q[ch], pix.data_in[ch]);
            hold_d[ch]     = hold_en ? pix.data_in[ch] : hold_q[ch];
            data_out_d[ch] = win_done ? smax(lb_rd[ch], rm[ch]) : data_out_q[ch];
        end
    end

    maxpool2_linebuf u_linebuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (lb_wr),
        .wr_addr (lb_addr),
        .wr_data (rm),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            valid_out_q <= 1'b0;
            for (int ch = 0; ch < L2_CHANNELS; ch++) begin
                hold_q[ch]     <= '0;
                data_out_q[ch] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            valid_out_q <= valid_out_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
        end
    end

    assign pix.valid_out = valid_out_q;
    assign pix.data_out  = data_out_q;

`ifdef MAXPOOL2_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;

    always_comb begin
        frame_done_d = win_done && (row_q == RowWinLast) && (col_q == ColWinLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
        end
    end

    assign pix.frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_maxpool2.sv
// Scoreboard bench for maxpool2: directed frames push expected windows, a negedge monitor checks.
`timescale 1ns/1ps
module tb_maxpool2;
    import cnn_pkg::*;

    localparam int W = L2_IMAGE_WIDTH;
    localparam int H = L2_IMAGE_HEIGHT;
    localparam int C = L2_CHANNELS;
    localparam int OW = POOL2_OUT_W;
    localparam int OH = POOL2_OUT_H;
    localparam int FRAME_OUTS = OW * OH;

    typedef logic [C*32-1:0] flat_t;
    typedef struct {
        int    due;
        flat_t data;
        bit    last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_out = 0;
    int   n_fd = 0;
    exp_t exp_q [$];

    exp_t  mon_e;
    bit    mon_due;
    bit    mon_fd;
    flat_t mon_got;
    int    mon_ch;

    maxpool2_if pix();

    maxpool2 dut (
        .clk (clk),
        .rst (rst),
        .pix (pix)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mode 0 ramp, mode 1 signed-compare windows, mode 2 odd-edge column/row only.
    function automatic logic [31:0] pix_val(input int mode, input int r, input int c, input int ch);
        if (mode == 0) return 32'(r * 100 + c + ch);
        if (mode == 1) begin
            if (r == 0) begin
                case (c)
                    0: return 32'hFFFF_FFFB;
                    1: return 32'hFFFF_FFFD;
                    2: return 32'h8000_0000;
                    3: return 32'd1;
                    4: return 32'hFFFF_FFFF;
                    5: return 32'd2;
                    default: return 32'd0;
                endcase
            end
            if (r == 1) begin
                case (c)
                    0: return 32'hFFFF_FFF9;
                    1: return 32'hFFFF_FFF7;
                    4: return 32'hFFFF_FFFC;
                    default: return 32'd0;
                endcase
            end
            return 32'd0;
        end
        return (c == W - 1 || r == H - 1) ? 32'd1000 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_val(input int mode, input int r, input int c, input int ch);
        if (mode == 0) return 32'((2 * r + 1) * 100 + 2 * c + 1 + ch);
        if (mode == 1 && r == 0) begin
            if (c == 0) return 32'hFFFF_FFFD;
            if (c == 1) return 32'd1;
            if (c == 2) return 32'd2;
        end
        return 32'd0;
    endfunction

    function automatic flat_t exp_flat(input int mode, input int r, input int c);
        flat_t f;
        for (int ch = 0; ch < C; ch++) f[ch*32 +: 32] = exp_val(mode, r, c, ch);
        return f;
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
        pix.valid_in = 1'b0;
    endtask

    task automatic send_pixel(input int mode, input int r, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        pix.valid_in = 1'b1;
        for (int ch = 0; ch < C; ch++) pix.data_in[ch] = pix_val(mode, r, c, ch);
        if (r < 2 * OH && c < 2 * OW && (r % 2) == 1 && (c % 2) == 1) begin
            e.due  = cyc + 1;
            e.data = exp_flat(mode, r / 2, c / 2);
            e.last = (r / 2 == OH - 1) && (c / 2 == OW - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int mode, input int max_gap);
        int unsigned g;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (max_gap > 0) begin
                    g = $urandom_range(max_gap, 0);
                    repeat (g) idle();
                end
                send_pixel(mode, r, c);
            end
        end
        idle();
    endtask

    task automatic check_frame(input string name, input int base_out, input int base_fd);
        repeat (3) idle();
        total++;
        if (n_out - base_out != FRAME_OUTS || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s out_count got=%0d want=%0d pending=%0d", name, n_out - base_out,
                     FRAME_OUTS, exp_q.size());
        end
`ifdef MAXPOOL2_FRAME_DONE_EN
        total++;
        if (n_fd - base_fd != 1) begin
            bad++;
            $display("FAIL %s frame_done_count got=%0d want=1", name, n_fd - base_fd);
        end
`else
        if (base_fd < 0) $display("unexpected negative base");
`endif
    endtask

    task automatic check_reset(input string name);
        bit nz;
        nz = 1'b0;
        for (int ch = 0; ch < C; ch++) if (pix.data_out[ch] !== 32'd0) nz = 1'b1;
        total++;
        if (pix.valid_out !== 1'b0 || nz) begin
            bad++;
            $display("FAIL %s valid_out=%b data_out_nonzero=%b want 0/0", name, pix.valid_out, nz);
        end
`ifdef MAXPOOL2_FRAME_DONE_EN
        total++;
        if (pix.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL %s frame_done got=%b want=0", name, pix.frame_done);
        end
`endif
    endtask

    // Monitor: valid_out must match exactly the cycles the scoreboard marks as due.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            mon_fd  = 1'b0;
            total++;
            if (pix.valid_out !== mon_due) begin
                bad++;
                $display("FAIL valid_out cyc=%0d got=%b want=%b", cyc, pix.valid_out, mon_due);
            end
            if (pix.valid_out === 1'b1) n_out++;
            if (mon_due) begin
                mon_e  = exp_q.pop_front();
                mon_fd = mon_e.last;
                for (int ch = 0; ch < C; ch++) mon_got[ch*32 +: 32] = pix.data_out[ch];
                total++;
                if (mon_got !== mon_e.data) begin
                    bad++;
                    mon_ch = 0;
                    for (int ch = C - 1; ch >= 0; ch--)
                        if (mon_got[ch*32 +: 32] !== mon_e.data[ch*32 +: 32]) mon_ch = ch;
                    $display("FAIL data_out cyc=%0d ch=%0d got=%h want=%h", cyc, mon_ch,
                             mon_got[mon_ch*32 +: 32], mon_e.data[mon_ch*32 +: 32]);
                end
            end
`ifdef MAXPOOL2_FRAME_DONE_EN
            total++;
            if (pix.frame_done !== mon_fd) begin
                bad++;
                $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, pix.frame_done, mon_fd);
            end
            if (pix.frame_done === 1'b1) n_fd++;
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bo;
        int bf;
        rst = 1'b1;
        pix.valid_in = 1'b0;
        for (int ch = 0; ch < C; ch++) pix.data_in[ch] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        bo = n_out; bf = n_fd; send_frame(0, 0); check_frame("ramp", bo, bf);
        bo = n_out; bf = n_fd; send_frame(1, 0); check_frame("signed", bo, bf);
        bo = n_out; bf = n_fd; send_frame(2, 0); check_frame("odd_edge", bo, bf);
        bo = n_out; bf = n_fd; send_frame(0, 0); check_frame("after_odd_edge", bo, bf);
        bo = n_out; bf = n_fd; send_frame(0, 5); check_frame("bubbles", bo, bf);

        for (int k = 0; k < 30; k++) send_pixel(0, k / W, k % W);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int ch = 0; ch < C; ch++) pix.data_in[ch] = 32'd777;
        @(negedge clk);
        check_reset("reset_mid");
        @(posedge clk);
        @(negedge clk);
        check_reset("reset_mid_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix.valid_in = 1'b0;

        bo = n_out; bf = n_fd; send_frame(0, 0); check_frame("after_reset", bo, bf);
        bo = n_out; bf = n_fd; send_frame(0, 0); check_frame("second_frame", bo, bf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
